// File: rtl/reg_wb_if.sv
// Bus bundle between register decode / execute / memory and the reg_wb stage.
// master: the decode/execute/memory side drives commits and issues and reads the registers.
// slave : reg_wb receives commits and issues and drives register contents, BUSY, STALL, WB_CNT and COLLIDE.
interface reg_wb_if;
  logic        WB_EN;
  logic [2:0]  N_REG_WB;
  logic [15:0] RESULT;
  logic        LD_EN;
  logic [2:0]  N_REG_LD;
  logic [15:0] LD_DATA;
  logic        ISSUE_EN;
  logic [2:0]  N_REG_ISSUE;
  logic [2:0]  N_REG_SRC;
  logic [15:0] REG0, REG1, REG2, REG3, REG4, REG5, REG6, REG7;
  logic [7:0]  BUSY;
  logic        STALL;
  logic [15:0] WB_CNT;
  logic        COLLIDE;

  modport master (
    output WB_EN, N_REG_WB, RESULT, LD_EN, N_REG_LD, LD_DATA,
           ISSUE_EN, N_REG_ISSUE, N_REG_SRC,
    input  REG0, REG1, REG2, REG3, REG4, REG5, REG6, REG7,
           BUSY, STALL, WB_CNT, COLLIDE
  );

  modport slave (
    input  WB_EN, N_REG_WB, RESULT, LD_EN, N_REG_LD, LD_DATA,
           ISSUE_EN, N_REG_ISSUE, N_REG_SRC,
    output REG0, REG1, REG2, REG3, REG4, REG5, REG6, REG7,
           BUSY, STALL, WB_CNT, COLLIDE
  );
endinterface

// File: rtl/reg_wb.sv
// Register file and write-back stage: eight 16-bit registers, busy scoreboard,
// commit counter and sticky WB/LD collision flag.
// Ports:
//   CLK_WB : stage clock, all state updates on the rising edge
//   RESET  : synchronous active-high reset
//   bus    : reg_wb_if.slave (commit/issue inputs; REG0..7, BUSY, STALL, WB_CNT, COLLIDE outputs)
module reg_wb (
  input  logic     CLK_WB,
  input  logic     RESET,
  reg_wb_if.slave  bus
);

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];
  logic [7:0]  busy_q, busy_d;
  logic [15:0] wb_cnt_q, wb_cnt_d;
  logic        collide_q, collide_d;

  logic        stall;
  logic        issue_ok;
  logic        same_dst;
  logic [1:0]  n_commit;

  always_comb begin
    // STALL looks only at the pre-edge scoreboard: no bypass from same-cycle commits.
    stall    = bus.ISSUE_EN & (busy_q[bus.N_REG_SRC] | busy_q[bus.N_REG_ISSUE]);
    issue_ok = bus.ISSUE_EN & ~stall;
    same_dst = bus.WB_EN & bus.LD_EN & (bus.N_REG_WB == bus.N_REG_LD);

    regs_d    = regs_q;
    busy_d    = busy_q;
    collide_d = collide_q | same_dst;

    // LD is applied after WB so load data wins on a shared destination.
    if (bus.WB_EN) begin
      regs_d[bus.N_REG_WB] = bus.RESULT;
      busy_d[bus.N_REG_WB] = 1'b0;
    end
    if (bus.LD_EN) begin
      regs_d[bus.N_REG_LD] = bus.LD_DATA;
      busy_d[bus.N_REG_LD] = 1'b0;
    end
    // Issue is applied last so it overrides a same-cycle clear.
    if (issue_ok) begin
      busy_d[bus.N_REG_ISSUE] = 1'b1;
    end

    // A collided pair counts as a single committed write.
    n_commit = {1'b0, bus.WB_EN} + {1'b0, bus.LD_EN} - {1'b0, same_dst};
    wb_cnt_d = wb_cnt_q + {14'd0, n_commit};
  end

  always_ff @(posedge CLK_WB) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      wb_cnt_q  <= '0;
      collide_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      wb_cnt_q  <= wb_cnt_d;
      collide_q <= collide_d;
    end
  end

  assign bus.REG0    = regs_q[0];
  assign bus.REG1    = regs_q[1];
  assign bus.REG2    = regs_q[2];
  assign bus.REG3    = regs_q[3];
  assign bus.REG4    = regs_q[4];
  assign bus.REG5    = regs_q[5];
  assign bus.REG6    = regs_q[6];
  assign bus.REG7    = regs_q[7];
  assign bus.BUSY    = busy_q;
  assign bus.STALL   = stall;
  assign bus.WB_CNT  = wb_cnt_q;
  assign bus.COLLIDE = collide_q;

endmodule
